// File: rtl/cordic_mult_pkg.sv
// cordic_mult_pkg: shared types and widths for the CORDIC multiplier arbiter.
package cordic_mult_pkg;
    typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;
    localparam int CORDIC_ITERS = 16;
    localparam int OPND_W       = 8;
    localparam int RES_W        = 16;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: picks the first asserted request at or after i_ptr (wrapping);
// returns a one-hot grant and its encoded index.
module rr_arbiter #(
    parameter int  N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);
    int w_best, w_dist;

    assign o_any = |i_req;

    always_comb begin
        w_best = N;
        w_dist = 0;
        o_idx  = '0;
        o_gnt  = '0;
        for (int j = 0; j < N; j++) begin
            w_dist = (j + N - int'(i_ptr)) % N;
            if (i_req[j] && w_dist < w_best) begin
                w_best = w_dist;
                o_idx  = IW'(j);
            end
        end
        o_gnt[o_idx] = o_any;
    end
endmodule

// File: rtl/cordic_mult_arbiter.sv
// cordic_mult_arbiter: round-robin front end sharing one sequential CORDIC multiplier.
// Define CORDIC_ARB_TIMEOUT_EN to build the RUN-state watchdog (TIMEOUT_CYCLES).
module cordic_mult_arbiter
    import cordic_mult_pkg::*;
#(
    parameter int  NUM_REQ        = 4,
    parameter int  TIMEOUT_CYCLES = 32,
    localparam int IW             = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    output logic [NUM_REQ-1:0]        o_req_ready,
    input  logic [NUM_REQ*OPND_W-1:0] i_req_x,
    input  logic [NUM_REQ*OPND_W-1:0] i_req_z,
    output logic                      o_rsp_valid,
    input  logic                      i_rsp_ready,
    output logic [IW-1:0]             o_rsp_id,
    output logic [RES_W-1:0]          o_rsp_y,
    output logic                      o_rsp_err,
    output logic                      o_mul_start,
    output logic [OPND_W-1:0]         o_mul_x,
    output logic [OPND_W-1:0]         o_mul_z,
    input  logic [RES_W-1:0]          i_mul_y,
    input  logic                      i_mul_done,
    output logic                      o_busy
);
    state_t             r_state, w_next;
    logic [IW-1:0]      r_ptr, w_idx;
    logic [NUM_REQ-1:0] w_gnt;
    logic               w_any, w_accept, w_finish, w_timeout;
    logic [OPND_W-1:0]  w_x, w_z;

    // The watchdog must outlast a normal iteration run.
    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES <= CORDIC_ITERS) begin : g_bad_cfg
        $error("cordic_mult_arbiter: unsupported parameter values");
    end

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .i_req (i_req_valid),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    always_comb begin
        w_x = '0;
        w_z = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                w_x = i_req_x[i*OPND_W +: OPND_W];
                w_z = i_req_z[i*OPND_W +: OPND_W];
            end
        end
    end

`ifdef CORDIC_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] r_cnt;
    logic          r_err;

    // Zero outside RUN, so it always starts from 0 on entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_cnt <= '0;
        else        r_cnt <= (r_state == RUN) ? r_cnt + CW'(1) : '0;
    end

    assign w_timeout = (r_state == RUN) && !i_mul_done && (r_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         r_err <= 1'b0;
        else if (w_accept)  r_err <= 1'b0;
        else if (w_timeout) r_err <= 1'b1;
    end

    assign o_rsp_err = r_err;
`else
    assign w_timeout = 1'b0;
    assign o_rsp_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_accept    = 1'b0;
        o_req_ready = '0;
        w_finish    = (r_state == RUN) && (i_mul_done || w_timeout);
        case (r_state)
            IDLE: if (w_any) begin
                w_next      = RUN;
                w_accept    = 1'b1;
                o_req_ready = rst_n ? w_gnt : '0;
            end
            RUN:     if (w_finish) w_next = RESP;
            RESP:    if (i_rsp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr       <= '0;
            o_mul_start <= 1'b0;
            o_mul_x     <= '0;
            o_mul_z     <= '0;
            o_rsp_id    <= '0;
            o_rsp_y     <= '0;
        end else if (w_accept) begin
            r_ptr       <= (w_idx == IW'(NUM_REQ - 1)) ? '0 : w_idx + IW'(1);
            o_mul_start <= 1'b1;
            o_mul_x     <= w_x;
            o_mul_z     <= w_z;
            o_rsp_id    <= w_idx;
        end else if (w_finish) begin
            o_mul_start <= 1'b0;
            o_rsp_y     <= w_timeout ? '0 : i_mul_y;
        end
    end

    assign o_rsp_valid = (r_state == RESP);
    assign o_busy      = (r_state != IDLE);
endmodule

// File: tb/tb_cordic_mult_arbiter.sv
// tb_cordic_mult_arbiter: directed table, corner sequences and randomized traffic
// against a behavioural multiplier model and a transaction-level scoreboard.
module tb_cordic_mult_arbiter;
    import cordic_mult_pkg::*;
    localparam int N = 4;

    logic clk = 1'b0, rst_n = 1'b1, hang = 1'b0;
    logic [N-1:0] req_valid = '0, req_ready;
    logic [N*8-1:0] req_x = '0, req_z = '0;
    logic rsp_valid, rsp_ready = 1'b1, rsp_err, mul_start, mul_done, busy;
    logic [1:0] rsp_id;
    logic [15:0] rsp_y, mul_y;
    logic [7:0] mul_x, mul_z;
    int checks = 0, failures = 0, cyc = 0, mcnt;

    cordic_mult_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(32)) dut (
        .clk(clk), .rst_n(rst_n), .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_x(req_x), .i_req_z(req_z), .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_id(rsp_id), .o_rsp_y(rsp_y), .o_rsp_err(rsp_err), .o_mul_start(mul_start),
        .o_mul_x(mul_x), .o_mul_z(mul_z), .i_mul_y(mul_y), .i_mul_done(mul_done), .o_busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, want);
        end
    endtask

    // Multiplier model: done 16 edges after start rises, cleared when start drops.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  mcnt <= 0;
        else if (!mul_start)         mcnt <= 0;
        else if (mcnt < CORDIC_ITERS) mcnt <= mcnt + 1;
    end
    assign mul_done = mul_start && mcnt == CORDIC_ITERS && !hang;
    assign mul_y    = 16'($signed(mul_x)) * 16'($signed(mul_z));

    // Scoreboard: round-robin grant prediction and an in-order response queue.
    typedef struct {int id; logic [15:0] y;} exp_t;
    exp_t sbq[$];
    exp_t sb_e;
    int sb_ptr = 0, sb_g;
    logic signed [15:0] sb_a, sb_b;
    always @(negedge clk) begin
        if (!rst_n) begin
            sbq.delete();
            sb_ptr = 0;
        end else if (sbq.size() == 0) begin
            sb_g = -1;
            for (int k = 0; k < N; k++)
                if (sb_g < 0 && req_valid[(sb_ptr + k) % N]) sb_g = (sb_ptr + k) % N;
            chk("sb_grant", req_ready, sb_g < 0 ? 0 : 1 << sb_g);
            if (sb_g >= 0) begin
                sb_a = 16'($signed(req_x[sb_g*8 +: 8]));
                sb_b = 16'($signed(req_z[sb_g*8 +: 8]));
                sbq.push_back('{sb_g, sb_a * sb_b});
                sb_ptr = (sb_g + 1) % N;
            end
        end else begin
            chk("sb_ready_busy", req_ready, 0);
            if (rsp_valid && rsp_ready) begin
                sb_e = sbq.pop_front();
                chk("sb_id", rsp_id, sb_e.id);
                chk("sb_err", rsp_err, hang);
                chk("sb_y", rsp_y, hang ? 16'h0 : sb_e.y);
            end
        end
    end

    // Operands constant while start is high; start must drop right after done.
    logic p_start = 1'b0, p_done = 1'b0;
    logic [7:0] run_x, run_z;
    always @(negedge clk) begin
        if (!rst_n) begin
            p_start = 1'b0;
            p_done  = 1'b0;
        end else begin
            if (mul_start && p_start) begin
                chk("opnd_hold_x", mul_x, run_x);
                chk("opnd_hold_z", mul_z, run_z);
            end
            if (p_start && p_done) chk("start_gap", mul_start, 0);
            if (mul_start && !p_start) begin
                run_x = mul_x;
                run_z = mul_z;
            end
            p_start = mul_start;
            p_done  = mul_done;
        end
    end

    task automatic all_zero(input string nm);
        chk({nm, "_start"}, mul_start, 0);
        chk({nm, "_mx"}, mul_x, 0);
        chk({nm, "_mz"}, mul_z, 0);
        chk({nm, "_valid"}, rsp_valid, 0);
        chk({nm, "_y"}, rsp_y, 0);
        chk({nm, "_id"}, rsp_id, 0);
        chk({nm, "_err"}, rsp_err, 0);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_ready"}, req_ready, 0);
    endtask

    task automatic op(input int id, input logic [7:0] x, input logic [7:0] z,
                      input logic [15:0] ey, input logic eerr, input int elat, input string nm);
        int n;
        @(posedge clk); #1;
        req_x[id*8 +: 8] = x;
        req_z[id*8 +: 8] = z;
        req_valid[id] = 1'b1;
        #1;
        n = 0;
        while (req_ready == '0 && n < 100) begin @(posedge clk); #2; n++; end
        chk({nm, "_ready"}, req_ready, 1 << id);
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
        n = 0;
        while (!rsp_valid && n < 100) begin @(posedge clk); #1; n++; end
        chk({nm, "_latency"}, n, elat);
        chk({nm, "_id"}, rsp_id, id);
        chk({nm, "_y"}, rsp_y, ey);
        chk({nm, "_err"}, rsp_err, eerr);
    endtask

    task automatic drain();
        int n;
        rsp_ready = 1'b1;
        req_valid = '0;
        n = 0;
        while ((busy || sbq.size() != 0) && n < 100) begin @(posedge clk); #1; n++; end
        chk("drain_timeout", n < 100, 1);
    endtask

    task automatic reset_pulse();
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    typedef struct {int id; logic [7:0] x; logic [7:0] z; logic [15:0] y;} vec_t;
    vec_t tbl[6];

    initial begin
        int n, t0;
        logic [15:0] hy;
        logic [1:0] hid;
        logic [N-1:0] granted;
        tbl[0] = '{2, 8'd5,  8'hFD, 16'hFFF1};
        tbl[1] = '{0, 8'h80, 8'h80, 16'h4000};
        tbl[2] = '{1, 8'h7F, 8'h7F, 16'h3F01};
        tbl[3] = '{3, 8'h80, 8'h7F, 16'hC080};
        tbl[4] = '{2, 8'h00, 8'hFF, 16'h0000};
        tbl[5] = '{0, 8'hFF, 8'hFF, 16'h0001};

        #1 rst_n = 1'b0;
        req_valid = '1;
        #2 all_zero("reset");
        req_valid = '0;
        @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            op(tbl[i].id, tbl[i].x, tbl[i].z, tbl[i].y, 1'b0, 17, $sformatf("tbl%0d", i));
            drain();
        end

        // Response stall with another requester waiting.
        rsp_ready = 1'b0;
        op(3, 8'd12, 8'hF6, 16'hFF88, 1'b0, 17, "stall");
        hy = rsp_y;
        hid = rsp_id;
        req_x[7:0] = 8'd9;
        req_z[7:0] = 8'd9;
        req_valid[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("stall_y", rsp_y, hy);
            chk("stall_id", rsp_id, hid);
            chk("stall_ready", req_ready, 0);
            chk("stall_start", mul_start, 0);
            chk("stall_valid", rsp_valid, 1);
        end
        drain();

        // Reset in the middle of a run; pointer must return to 0.
        @(posedge clk); #1;
        req_x[23:16] = 8'd7;
        req_z[23:16] = 8'd9;
        req_valid[2] = 1'b1;
        #1 chk("mid_accept", req_ready, 4'b0100);
        @(posedge clk); #1 req_valid = '0;
        repeat (8) @(posedge clk);
        #2 chk("mid_busy_before", busy, 1);
        req_valid = 4'b1010;
        rst_n = 1'b0;
        #1 all_zero("midrst");
        @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
        #1 chk("midrst_first_grant", req_ready, 4'b0010);
        @(posedge clk); #1 req_valid = '0;
        drain();

        // Full contention from a fresh pointer.
        reset_pulse();
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) begin
            req_x[i*8 +: 8] = 8'(i * 10 + 1);
            req_z[i*8 +: 8] = 8'(-(i + 2));
        end
        req_valid = '1;
        t0 = 0;
        for (int k = 0; k < 5; k++) begin
            n = 0;
            #1;
            while (req_ready == '0 && n < 100) begin @(posedge clk); #2; n++; end
            chk("cont_order", req_ready, 1 << (k % N));
            if (k > 0) chk("cont_period", cyc - t0, 19);
            t0 = cyc;
            @(posedge clk); #1;
        end
        drain();

        // Randomized traffic with legal withdrawals and random back-pressure.
        granted = '0;
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (granted[i]) req_valid[i] = 1'b0;
                else if (req_valid[i] && $urandom_range(0, 31) == 0) req_valid[i] = 1'b0;
                else if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                    req_valid[i] = 1'b1;
                    req_x[i*8 +: 8] = 8'($urandom);
                    req_z[i*8 +: 8] = 8'($urandom);
                end
            end
            rsp_ready = $urandom_range(0, 3) != 0;
            #1 granted = req_ready;
        end
        drain();

`ifdef CORDIC_ARB_TIMEOUT_EN
        hang = 1'b1;
        op(0, 8'd3, 8'd4, 16'h0000, 1'b1, 32, "wdog");
        drain();
        hang = 1'b0;
        op(1, 8'd3, 8'd4, 16'd12, 1'b0, 17, "wdog_next");
        drain();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit reached");
    end
endmodule

// File: doc/cordic_mult_arbiter.md
# cordic_mult_arbiter

Round-robin scheduler that shares one sequential CORDIC multiplier (8b×8b signed in, 16b result, `start`-held/`done`-pulse protocol) among `NUM_REQ` requesters. It arbitrates and latches operands, then drives the multiplier's `start`, `x` and `z` for the full iteration run. It captures the result on `done` and returns it through a valid/ready response port tagged with the requester ID. It sits between the accelerator's request fabric and the multiplier instance.

## Interface
- `NUM_REQ`, default 4: number of requesters (2..8).
- `TIMEOUT_CYCLES`, default 32: watchdog limit in the RUN state (used only with the macro).
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in NUM_REQ: per-requester request.
- `req_ready` out NUM_REQ: one-hot accept. At most one bit is high.
- `req_x` in NUM_REQ*8: signed x operands, packed; requester i occupies `[8i+7:8i]`.
- `req_z` in NUM_REQ*8: signed z operands, packed the same way.
- `rsp_valid` out 1: result available.
- `rsp_ready` in 1: consumer accepts the result.
- `rsp_id` out $clog2(NUM_REQ): requester that owns the result.
- `rsp_y` out 16: captured multiplier result.
- `rsp_err` out 1: watchdog abort flag. Tied to 0 without the macro.
- `mul_start` out 1: to multiplier `start`. Registered.
- `mul_x`, `mul_z` out 8 each: to multiplier operands. Registered.
- `mul_y` in 16: from multiplier `y`.
- `mul_done` in 1: from multiplier `done`.
- `busy` out 1: high when state ≠ IDLE.

## Operation
- FSM has three states: IDLE, RUN, RESP. Reset state is IDLE.
- **IDLE**
  - If any `req_valid` is high, the round-robin arbiter picks grant g: the first valid requester at or after pointer `ptr`, wrapping.
  - `req_ready[g]` = 1 combinationally.
  - At the clock edge: latch `req_x[g]`, `req_z[g]` into `mul_x`/`mul_z`; latch g into `rsp_id`; set `mul_start` to 1; set `ptr` to g+1 mod NUM_REQ; go to RUN.
  - With no valid requests, remain in IDLE with `mul_start` = 0.
- **RUN**
  - `mul_start` = 1.
  - `mul_x`, `mul_z` and `rsp_id` are held constant; the multiplier samples x every iteration.
  - `req_ready` = 0.
  - On `mul_done` = 1: capture `mul_y` into `rsp_y`, clear `mul_start`, go to RESP.
- **RESP**
  - `rsp_valid` = 1.
  - `rsp_y`, `rsp_id` and `rsp_err` are stable until the handshake.
  - `mul_start` = 0, which clears the multiplier iteration counter.
  - On `rsp_valid` && `rsp_ready`: go to IDLE.
  - No request is accepted in RESP. This guarantees `mul_start` is low for at least one cycle between operations.
- Requester rules:
  - A requester must hold `req_valid` and its operands stable until `req_ready`.
  - Deasserting `req_valid` without being granted is legal; that requester is simply not granted.
- Reset (asynchronous, any state, including mid-RUN): all of the following clear to 0 immediately:
  - state → IDLE
  - `ptr`
  - `mul_start`, `mul_x`, `mul_z`
  - `rsp_valid`, `rsp_y`, `rsp_id`, `rsp_err`
  - `busy`
  - `req_ready` (0 for the duration of reset)

## Timing
- Accept edge is E0. `mul_start` is high from E0.
- The multiplier raises `done` after E16. The result is captured at E17, and `rsp_valid` is high from E17.
- Accept-to-`rsp_valid` latency: 17 cycles.
- With `rsp_ready` tied high: RESP→IDLE at E18, next accept at E19. Sustained period is 19 cycles per operation.
- `rsp_ready` low stalls indefinitely; all outputs hold.
- Fairness: under continuous contention every requester is served within NUM_REQ operations.

## Configuration
- Macro: `CORDIC_ARB_TIMEOUT_EN`.
- **Defined:**
  - A cycle counter runs in RUN and clears on entry to RUN.
  - If it reaches `TIMEOUT_CYCLES` without `mul_done`: go to RESP with `rsp_err` = 1, `rsp_y` = 0, `mul_start` = 0.
  - `rsp_err` clears on the next accept.
- **Undefined:**
  - No counter is built.
  - RUN waits for `mul_done` indefinitely.
  - `rsp_err` is constant 0.

## Structure
- Package `cordic_mult_pkg` holds:
  - state enum (IDLE, RUN, RESP)
  - `CORDIC_ITERS` = 16
  - `OPND_W` = 8
  - `RES_W` = 16
- One sub-module: `rr_arbiter`. It is parameterised by N; it takes the request vector and the pointer and returns a one-hot grant plus the encoded index.
- The multiplier is not instantiated inside this block; the top level wires the `mul_*` ports to it.

## Test plan
The bench model of the multiplier raises `done` 16 cycles after `start` rises, drives `y` = x*z, and clears when `start` drops.
- **Single request:** requester 2, x=5, z=-3 → `rsp_valid` exactly 17 cycles after the accept, `rsp_id`=2, `rsp_y`=16'hFFF1.
- **Full contention:** all 4 requesters valid continuously, `rsp_ready`=1 → grant order 0,1,2,3,0, one accept every 19 cycles.
- **Response stall:** `rsp_ready` low for 10 cycles in RESP → `rsp_y` and `rsp_id` stable, `req_ready`=0, `mul_start`=0 throughout.
- **Operand and start integrity:** `mul_x`/`mul_z` are constant through RUN, and `mul_start` is low for ≥1 cycle between consecutive operations. The model flags an error if `start` is held across two operations.
- **Reset mid-run:** `rst_n` low at RUN cycle 8 → all outputs 0 without waiting for a clock edge. After release, with requesters 1 and 3 valid, the first grant is 1 (`ptr` = 0).
- **Watchdog:** with `CORDIC_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=32 and the model never raising `done` → `rsp_valid` after 32 RUN cycles with `rsp_err`=1 and `rsp_y`=0. The next normal operation returns `rsp_err`=0.
